// File: rtl/inst_fetch_pkg.sv
// Shared fetch-stage definitions: instruction width, bubble/reset constants,
// and the instruction-queue entry layout.
package inst_fetch_pkg;

   localparam int unsigned IW = 16;

   localparam logic [IW-1:0] IF_NOP_INST = 16'h0800;
   localparam logic [IW-1:0] IF_RESET_PC = 16'h0000;

   typedef struct packed {
      logic [IW-1:0] pc_plus1;
      logic [IW-1:0] inst;
   } fetch_entry_t;

endpackage

// File: rtl/inst_fetch_queue.sv
// fetch_queue: synchronous FIFO of fetched {pc+1, inst} pairs; flush beats push/pop.
module fetch_queue
   import inst_fetch_pkg::*;
#(
   parameter int unsigned DEPTH = 2,
   localparam int unsigned CW = $clog2(DEPTH) + 1
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          flush_i,
   input  logic          push_i,
   input  fetch_entry_t  push_data_i,
   input  logic          pop_i,
   output fetch_entry_t  pop_data_o,
   output logic          full_o,
   output logic          empty_o,
   output logic [CW-1:0] count_o
);

   localparam int unsigned PW = $clog2(DEPTH);

   fetch_entry_t  mem_q [DEPTH];
   logic [PW-1:0] rd_q, rd_d, wr_q, wr_d;
   logic [CW-1:0] cnt_q, cnt_d;

   always_comb begin
      rd_d  = rd_q;
      wr_d  = wr_q;
      cnt_d = cnt_q;
      if (flush_i) begin
         rd_d  = '0;
         wr_d  = '0;
         cnt_d = '0;
      end else begin
         if (push_i) wr_d = wr_q + PW'(1);
         if (pop_i)  rd_d = rd_q + PW'(1);
         if (push_i && !pop_i)      cnt_d = cnt_q + CW'(1);
         else if (pop_i && !push_i) cnt_d = cnt_q - CW'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         rd_q  <= '0;
         wr_q  <= '0;
         cnt_q <= '0;
      end else begin
         rd_q  <= rd_d;
         wr_q  <= wr_d;
         cnt_q <= cnt_d;
      end
   end

   // Storage needs no reset; only pointers/count define validity.
   always_ff @(posedge clk) begin
      if (push_i && !flush_i) mem_q[wr_q] <= push_data_i;
   end

   assign pop_data_o = mem_q[rd_q];
   assign full_o     = (cnt_q == CW'(DEPTH));
   assign empty_o    = (cnt_q == '0);
   assign count_o    = cnt_q;

endmodule

// File: rtl/inst_fetch.sv
// Instruction fetch stage: fetch PC, prefetch queue, and IF/ID output registers
// with squash-on-redirect and hold support.
module inst_fetch
   import inst_fetch_pkg::*;
#(
   parameter logic [IW-1:0] RESET_PC = IF_RESET_PC,
   parameter logic [IW-1:0] NOP_INST = IF_NOP_INST,
   parameter int unsigned   DEPTH    = 2
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          hold,
   input  logic          redirect,
   input  logic [IW-1:0] redirect_pc,
   output logic          mem_req,
   output logic [IW-1:0] mem_addr,
   input  logic          mem_ack,
   input  logic [IW-1:0] mem_rdata,
   output logic [IW-1:0] pc_out,
   output logic [IW-1:0] inst_out,
   output logic          inst_valid
);

   localparam int unsigned CW = $clog2(DEPTH) + 1;

   logic [IW-1:0] fpc_q, fpc_d;
   logic [IW-1:0] pc_q, pc_d;
   logic [IW-1:0] inst_q, inst_d;
   logic          valid_q, valid_d;

   logic          push, pop;
   logic          q_full, q_empty;
   logic [CW-1:0] q_count;
   fetch_entry_t  push_data, head;

   assign mem_req   = !rst && !redirect && (q_count < CW'(DEPTH));
   assign mem_addr  = fpc_q;
   assign push      = mem_req && mem_ack;
   assign push_data = '{pc_plus1: fpc_q + IW'(1), inst: mem_rdata};

   fetch_queue #(.DEPTH(DEPTH)) u_queue (
      .clk         (clk),
      .rst         (rst),
      .flush_i     (redirect),
      .push_i      (push),
      .push_data_i (push_data),
      .pop_i       (pop),
      .pop_data_o  (head),
      .full_o      (q_full),
      .empty_o     (q_empty),
      .count_o     (q_count)
   );

   // Redirect squashes even under hold; hold freezes outputs but not fetching.
   always_comb begin
      fpc_d   = fpc_q;
      pc_d    = pc_q;
      inst_d  = inst_q;
      valid_d = valid_q;
      pop     = 1'b0;
      if (redirect) begin
         fpc_d   = redirect_pc;
         pc_d    = '0;
         inst_d  = NOP_INST;
         valid_d = 1'b0;
      end else begin
         if (push) fpc_d = fpc_q + IW'(1);
         if (!hold) begin
            if (!q_empty) begin
               pop     = 1'b1;
               pc_d    = head.pc_plus1;
               inst_d  = head.inst;
               valid_d = 1'b1;
            end else begin
               pc_d    = '0;
               inst_d  = NOP_INST;
               valid_d = 1'b0;
            end
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         fpc_q   <= RESET_PC;
         pc_q    <= '0;
         inst_q  <= NOP_INST;
         valid_q <= 1'b0;
      end else begin
         fpc_q   <= fpc_d;
         pc_q    <= pc_d;
         inst_q  <= inst_d;
         valid_q <= valid_d;
      end
   end

   assign pc_out     = pc_q;
   assign inst_out   = inst_q;
   assign inst_valid = valid_q;

   count_full_a: assert property (@(posedge clk) disable iff (rst)
      q_full == (q_count == CW'(DEPTH)));

endmodule

// File: tb/tb_inst_fetch.sv
// Directed bench for inst_fetch: vector table for the main flows, hand-written
// sequences for reset state and reset during a memory wait.
module tb_inst_fetch;

   logic        clk = 1'b0;
   logic        rst, hold, redirect, mem_ack;
   logic [15:0] redirect_pc;
   logic        mem_req, inst_valid;
   logic [15:0] mem_addr, mem_rdata, pc_out, inst_out;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   // Memory model: word at address a is a ^ A000.
   assign mem_rdata = mem_addr ^ 16'hA000;

   inst_fetch dut (
      .clk         (clk),
      .rst         (rst),
      .hold        (hold),
      .redirect    (redirect),
      .redirect_pc (redirect_pc),
      .mem_req     (mem_req),
      .mem_addr    (mem_addr),
      .mem_ack     (mem_ack),
      .mem_rdata   (mem_rdata),
      .pc_out      (pc_out),
      .inst_out    (inst_out),
      .inst_valid  (inst_valid)
   );

   typedef struct {
      logic        hold;
      logic        redir;
      logic [15:0] rpc;
      logic        ack;
      logic        ereq;
      logic [15:0] eaddr;
      logic        evalid;
      logic [15:0] einst;
      logic [15:0] epc;
   } vec_t;

   vec_t vecs[$];

   task automatic chk(input string name, input int idx, input logic [15:0] act,
                      input logic [15:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s step %0d: got %h expected %h", name, idx, act, exp);
      end
   endtask

   task automatic add(input logic h, input logic r, input logic [15:0] rpc,
                      input logic a, input logic er, input logic [15:0] ea,
                      input logic ev, input logic [15:0] ei, input logic [15:0] ep);
      vec_t v;
      v = '{hold: h, redir: r, rpc: rpc, ack: a, ereq: er, eaddr: ea,
            evalid: ev, einst: ei, epc: ep};
      vecs.push_back(v);
   endtask

   // Drive one cycle: check request/address before the edge, outputs after it.
   task automatic step(input int idx, input logic r_in, input logic h, input logic rd,
                       input logic [15:0] rpc, input logic a, input logic er,
                       input logic [15:0] ea, input logic ev, input logic [15:0] ei,
                       input logic [15:0] ep);
      rst = r_in; hold = h; redirect = rd; redirect_pc = rpc; mem_ack = a;
      #1;
      chk("mem_req", idx, 16'(mem_req), 16'(er));
      chk("mem_addr", idx, mem_addr, ea);
      @(posedge clk);
      #1;
      chk("inst_valid", idx, 16'(inst_valid), 16'(ev));
      chk("inst_out", idx, inst_out, ei);
      chk("pc_out", idx, pc_out, ep);
   endtask

   initial begin
      rst = 1'b1; hold = 1'b0; redirect = 1'b0; redirect_pc = '0; mem_ack = 1'b1;

      // Reset state
      #1;
      chk("rst_mem_req", 0, 16'(mem_req), 16'h0);
      @(posedge clk);
      #1;
      chk("rst_valid", 0, 16'(inst_valid), 16'h0);
      chk("rst_inst", 0, inst_out, 16'h0800);
      chk("rst_pc", 0, pc_out, 16'h0000);
      chk("rst_addr", 0, mem_addr, 16'h0000);
      chk("rst_req_hi", 0, 16'(mem_req), 16'h0);

      //   hold redir rpc      ack  req addr     valid inst      pc
      // free-running
      add(0, 0, 16'h0000, 1,   1, 16'h0000, 0, 16'h0800, 16'h0000);
      add(0, 0, 16'h0000, 1,   1, 16'h0001, 1, 16'hA000, 16'h0001);
      add(0, 0, 16'h0000, 1,   1, 16'h0002, 1, 16'hA001, 16'h0002);
      add(0, 0, 16'h0000, 1,   1, 16'h0003, 1, 16'hA002, 16'h0003);
      add(0, 0, 16'h0000, 1,   1, 16'h0004, 1, 16'hA003, 16'h0004);
      // hold 5 cycles: queue fills, request drops
      add(1, 0, 16'h0000, 1,   1, 16'h0005, 1, 16'hA003, 16'h0004);
      add(1, 0, 16'h0000, 1,   0, 16'h0006, 1, 16'hA003, 16'h0004);
      add(1, 0, 16'h0000, 1,   0, 16'h0006, 1, 16'hA003, 16'h0004);
      add(1, 0, 16'h0000, 1,   0, 16'h0006, 1, 16'hA003, 16'h0004);
      add(1, 0, 16'h0000, 1,   0, 16'h0006, 1, 16'hA003, 16'h0004);
      // release: back-to-back
      add(0, 0, 16'h0000, 1,   0, 16'h0006, 1, 16'hA004, 16'h0005);
      add(0, 0, 16'h0000, 1,   1, 16'h0006, 1, 16'hA005, 16'h0006);
      add(0, 0, 16'h0000, 1,   1, 16'h0007, 1, 16'hA006, 16'h0007);
      // wait states: ack every third cycle
      add(0, 0, 16'h0000, 0,   1, 16'h0008, 1, 16'hA007, 16'h0008);
      add(0, 0, 16'h0000, 0,   1, 16'h0008, 0, 16'h0800, 16'h0000);
      add(0, 0, 16'h0000, 1,   1, 16'h0008, 0, 16'h0800, 16'h0000);
      add(0, 0, 16'h0000, 0,   1, 16'h0009, 1, 16'hA008, 16'h0009);
      add(0, 0, 16'h0000, 0,   1, 16'h0009, 0, 16'h0800, 16'h0000);
      add(0, 0, 16'h0000, 1,   1, 16'h0009, 0, 16'h0800, 16'h0000);
      add(0, 0, 16'h0000, 1,   1, 16'h000A, 1, 16'hA009, 16'h000A);
      // fill queue, then redirect to 0040 with ack high
      add(1, 0, 16'h0000, 1,   1, 16'h000B, 1, 16'hA009, 16'h000A);
      add(0, 1, 16'h0040, 1,   0, 16'h000C, 0, 16'h0800, 16'h0000);
      add(0, 0, 16'h0000, 1,   1, 16'h0040, 0, 16'h0800, 16'h0000);
      add(0, 0, 16'h0000, 1,   1, 16'h0041, 1, 16'hA040, 16'h0041);
      add(0, 0, 16'h0000, 1,   1, 16'h0042, 1, 16'hA041, 16'h0042);
      // redirect under hold to FFFF, then address wrap
      add(1, 1, 16'hFFFF, 1,   0, 16'h0043, 0, 16'h0800, 16'h0000);
      add(0, 0, 16'h0000, 1,   1, 16'hFFFF, 0, 16'h0800, 16'h0000);
      add(0, 0, 16'h0000, 1,   1, 16'h0000, 1, 16'h5FFF, 16'h0000);
      add(0, 0, 16'h0000, 1,   1, 16'h0001, 1, 16'hA000, 16'h0001);

      for (int i = 0; i < vecs.size(); i++) begin
         step(i + 1, 1'b0, vecs[i].hold, vecs[i].redir, vecs[i].rpc, vecs[i].ack,
              vecs[i].ereq, vecs[i].eaddr, vecs[i].evalid, vecs[i].einst, vecs[i].epc);
      end

      // Reset while a fetch is waiting and the queue holds an entry
      step(100, 0, 0, 0, 16'h0, 1, 1, 16'h0002, 1, 16'hA001, 16'h0002);
      step(101, 0, 1, 0, 16'h0, 0, 1, 16'h0003, 1, 16'hA001, 16'h0002);
      step(102, 1, 1, 0, 16'h0, 0, 0, 16'h0003, 0, 16'h0800, 16'h0000);
      step(103, 0, 0, 0, 16'h0, 0, 1, 16'h0000, 0, 16'h0800, 16'h0000);
      step(104, 0, 0, 0, 16'h0, 1, 1, 16'h0000, 0, 16'h0800, 16'h0000);
      step(105, 0, 0, 0, 16'h0, 1, 1, 16'h0001, 1, 16'hA000, 16'h0001);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
